// File: rtl/pipe_front_regs_pkg.sv
// Shared widths, reset encodings and the ID/EX bubble for the CPU front-end pipeline registers.
// Constants only; no timing or flow control here.
package pipe_pkg;

    localparam int unsigned PC_W    = 16;
    localparam int unsigned INSTR_W = 16;
    localparam int unsigned REG_W   = 4;
    localparam int unsigned CTRL_W  = 8;

    localparam logic [PC_W-1:0]    RESET_PC  = 16'h0000;
    localparam logic [INSTR_W-1:0] NOP_INSTR = 16'h0000;

    typedef struct packed {
        logic [REG_W-1:0]  op1;
        logic [REG_W-1:0]  op2;
        logic [REG_W-1:0]  rd;
        logic [CTRL_W-1:0] ctrl;
        logic              mem_read;
        logic              mem_write;
        logic              reg_write;
        logic [PC_W-1:0]   pc;
    } idex_t;

    // All-zero bubble: no side effects, and op1==0 with MemRead==0 raises no false load-use hazard.
    localparam idex_t IDEX_BUBBLE = '0;

    // Legal hazard controls: a stall freezes both PC and IF/ID, otherwise both advance together.
    function automatic logic hazard_ctrl_illegal(input logic stall, input logic pc_write,
                                                 input logic ifid_write);
        return (stall && (pc_write || ifid_write)) || (pc_write != ifid_write);
    endfunction

endpackage

// File: rtl/pipe_front_regs_sat_counter.sv
// Saturating event counter: counts one per cycle with inc high, sticks at all-ones.
// Latency 1 cycle, synchronous active-low reset, no backpressure.
module sat_counter #(
    parameter int unsigned W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    output logic [W-1:0] count
);

    logic [W-1:0] r_count;
    logic         w_at_max;

    assign w_at_max = (r_count == {W{1'b1}});

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_count <= '0;
        end else if (inc && !w_at_max) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign count = r_count;

endmodule

// File: rtl/pipe_front_regs.sv
// PC, IF/ID and ID/EX registers with stall bubbles and branch flush, plus debug counters.
// All outputs registered (1 cycle); stalls come from the hazard unit, a taken branch overrides them.
module pipe_front_regs
    import pipe_pkg::*;
#(
    parameter int unsigned PC_INC = 1,
    parameter int unsigned CNT_W  = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               STALL,
    input  logic               PCWrite,
    input  logic               IFID_Write,
    input  logic               br_taken,
    input  logic [PC_W-1:0]    br_target,
    input  logic [INSTR_W-1:0] imem_instr,
    input  logic [REG_W-1:0]   id_op1,
    input  logic [REG_W-1:0]   id_op2,
    input  logic [REG_W-1:0]   id_rd,
    input  logic [CTRL_W-1:0]  id_ctrl,
    input  logic               id_MemRead,
    input  logic               id_MemWrite,
    input  logic               id_RegWrite,
    output logic [PC_W-1:0]    pc,
    output logic [INSTR_W-1:0] IFID_instr,
    output logic [PC_W-1:0]    IFID_pc,
    output logic               IFID_valid,
    output logic [REG_W-1:0]   IDEX_op1,
    output logic [REG_W-1:0]   IDEX_op2,
    output logic [REG_W-1:0]   IDEX_rd,
    output logic [CTRL_W-1:0]  IDEX_ctrl,
    output logic               IDEX_MemRead,
    output logic               IDEX_MemWrite,
    output logic               IDEX_RegWrite,
    output logic [PC_W-1:0]    IDEX_pc,
    output logic [CNT_W-1:0]   stall_cnt,
    output logic [CNT_W-1:0]   flush_cnt,
    output logic               proto_err
);

    localparam logic [PC_W-1:0] PC_STEP = PC_W'(PC_INC);

    logic [PC_W-1:0]    r_pc;
    logic [INSTR_W-1:0] r_ifid_instr;
    logic [PC_W-1:0]    r_ifid_pc;
    logic               r_ifid_vld;
    idex_t              r_idex;
    logic               r_proto_err;
    logic               w_stall_inc;
    logic               w_proto_viol;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_pc <= RESET_PC;
        end else if (br_taken) begin
            r_pc <= br_target;
        end else if (PCWrite) begin
            r_pc <= r_pc + PC_STEP;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst || br_taken) begin
            r_ifid_instr <= NOP_INSTR;
            r_ifid_pc    <= '0;
            r_ifid_vld   <= 1'b0;
        end else if (IFID_Write) begin
            r_ifid_instr <= imem_instr;
            r_ifid_pc    <= r_pc;
            r_ifid_vld   <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst || br_taken || STALL) begin
            r_idex <= IDEX_BUBBLE;
        end else begin
            r_idex.op1       <= id_op1;
            r_idex.op2       <= id_op2;
            r_idex.rd        <= id_rd;
            r_idex.ctrl      <= id_ctrl;
            r_idex.mem_read  <= id_MemRead;
            r_idex.mem_write <= id_MemWrite;
            r_idex.reg_write <= id_RegWrite;
            r_idex.pc        <= r_ifid_pc;
        end
    end

    // Flagged only; the datapath above still follows each control individually.
    assign w_proto_viol = hazard_ctrl_illegal(STALL, PCWrite, IFID_Write);

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_proto_err <= 1'b0;
        end else if (w_proto_viol) begin
            r_proto_err <= 1'b1;
        end
    end

    assign w_stall_inc = STALL && !br_taken;

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (w_stall_inc),
        .count (stall_cnt)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (br_taken),
        .count (flush_cnt)
    );

    assign pc            = r_pc;
    assign IFID_instr    = r_ifid_instr;
    assign IFID_pc       = r_ifid_pc;
    assign IFID_valid    = r_ifid_vld;
    assign IDEX_op1      = r_idex.op1;
    assign IDEX_op2      = r_idex.op2;
    assign IDEX_rd       = r_idex.rd;
    assign IDEX_ctrl     = r_idex.ctrl;
    assign IDEX_MemRead  = r_idex.mem_read;
    assign IDEX_MemWrite = r_idex.mem_write;
    assign IDEX_RegWrite = r_idex.reg_write;
    assign IDEX_pc       = r_idex.pc;
    assign proto_err     = r_proto_err;

endmodule

// File: tb/tb_pipe_front_regs.sv
// Directed scenarios plus a randomized run against a cycle-level model of the front-end registers.
module tb_pipe_front_regs;

    localparam int CNT_W   = 2;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic        clk = 1'b0;
    logic        rst, STALL, PCWrite, IFID_Write, br_taken;
    logic [15:0] br_target, imem_instr;
    logic [3:0]  id_op1, id_op2, id_rd;
    logic [7:0]  id_ctrl;
    logic        id_MemRead, id_MemWrite, id_RegWrite;
    logic [15:0] pc, IFID_instr, IFID_pc, IDEX_pc;
    logic        IFID_valid;
    logic [3:0]  IDEX_op1, IDEX_op2, IDEX_rd;
    logic [7:0]  IDEX_ctrl;
    logic        IDEX_MemRead, IDEX_MemWrite, IDEX_RegWrite;
    logic [CNT_W-1:0] stall_cnt, flush_cnt;
    logic        proto_err;

    int n_checks = 0;
    int n_errors = 0;

    // Reference state, updated from the behavioural rules once per clock edge.
    logic [15:0] m_pc, m_if_instr, m_if_pc, m_ex_pc;
    logic        m_if_vld, m_err;
    logic [3:0]  m_ex_op1, m_ex_op2, m_ex_rd;
    logic [7:0]  m_ex_ctrl;
    logic        m_ex_mr, m_ex_mw, m_ex_rw;
    int          m_stall, m_flush;

    always #5 clk = ~clk;

    pipe_front_regs #(.PC_INC(1), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .STALL(STALL), .PCWrite(PCWrite), .IFID_Write(IFID_Write),
        .br_taken(br_taken), .br_target(br_target), .imem_instr(imem_instr),
        .id_op1(id_op1), .id_op2(id_op2), .id_rd(id_rd), .id_ctrl(id_ctrl),
        .id_MemRead(id_MemRead), .id_MemWrite(id_MemWrite), .id_RegWrite(id_RegWrite),
        .pc(pc), .IFID_instr(IFID_instr), .IFID_pc(IFID_pc), .IFID_valid(IFID_valid),
        .IDEX_op1(IDEX_op1), .IDEX_op2(IDEX_op2), .IDEX_rd(IDEX_rd), .IDEX_ctrl(IDEX_ctrl),
        .IDEX_MemRead(IDEX_MemRead), .IDEX_MemWrite(IDEX_MemWrite), .IDEX_RegWrite(IDEX_RegWrite),
        .IDEX_pc(IDEX_pc), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt), .proto_err(proto_err)
    );

    task automatic randomize_id();
        imem_instr  = 16'($urandom);
        id_op1      = 4'($urandom);
        id_op2      = 4'($urandom);
        id_rd       = 4'($urandom);
        id_ctrl     = 8'($urandom);
        id_MemRead  = 1'($urandom);
        id_MemWrite = 1'($urandom);
        id_RegWrite = 1'($urandom);
    endtask

    task automatic set_ctrl(input logic stall, input logic pcw, input logic ifw, input logic br);
        STALL = stall; PCWrite = pcw; IFID_Write = ifw; br_taken = br;
    endtask

    // Advance the model using the current inputs, then let the DUT take the same edge.
    task automatic step();
        if (!rst) begin
            m_pc = 16'h0000; m_if_instr = 16'h0000; m_if_pc = 16'h0000; m_if_vld = 1'b0;
            {m_ex_op1, m_ex_op2, m_ex_rd, m_ex_ctrl, m_ex_mr, m_ex_mw, m_ex_rw, m_ex_pc} = '0;
            m_stall = 0; m_flush = 0; m_err = 1'b0;
        end else begin
            if (br_taken || STALL)
                {m_ex_op1, m_ex_op2, m_ex_rd, m_ex_ctrl, m_ex_mr, m_ex_mw, m_ex_rw, m_ex_pc} = '0;
            else
                {m_ex_op1, m_ex_op2, m_ex_rd, m_ex_ctrl, m_ex_mr, m_ex_mw, m_ex_rw, m_ex_pc} =
                    {id_op1, id_op2, id_rd, id_ctrl, id_MemRead, id_MemWrite, id_RegWrite, m_if_pc};
            if (br_taken) begin
                m_if_instr = 16'h0000; m_if_pc = 16'h0000; m_if_vld = 1'b0;
            end else if (IFID_Write) begin
                m_if_instr = imem_instr; m_if_pc = m_pc; m_if_vld = 1'b1;
            end
            if (br_taken)     m_pc = br_target;
            else if (PCWrite) m_pc = 16'((32'(m_pc) + 1) % 65536);
            if (STALL && !br_taken && m_stall < CNT_MAX) m_stall++;
            if (br_taken && m_flush < CNT_MAX) m_flush++;
            if ((STALL && (PCWrite || IFID_Write)) || (PCWrite != IFID_Write)) m_err = 1'b1;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        for (int i = 0; i < 2; i++) begin
            randomize_id();
            set_ctrl(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
            br_target = 16'($urandom);
            step();
        end
        n_checks++; if (pc !== 16'h0000) begin n_errors++; $display("FAIL reset_pc: got %h want 0000", pc); end
        n_checks++; if (IFID_valid !== 1'b0) begin n_errors++; $display("FAIL reset_ifid_valid: got %b want 0", IFID_valid); end
        n_checks++; if ({IFID_instr, IFID_pc} !== 32'h0) begin n_errors++; $display("FAIL reset_ifid: got %h want 0", {IFID_instr, IFID_pc}); end
        n_checks++; if ({IDEX_op1, IDEX_op2, IDEX_rd, IDEX_ctrl, IDEX_MemRead, IDEX_MemWrite, IDEX_RegWrite, IDEX_pc} !== 47'h0) begin
            n_errors++; $display("FAIL reset_idex: got %h want 0", {IDEX_op1, IDEX_op2, IDEX_rd, IDEX_ctrl, IDEX_MemRead, IDEX_MemWrite, IDEX_RegWrite, IDEX_pc}); end
        n_checks++; if ({stall_cnt, flush_cnt} !== '0) begin n_errors++; $display("FAIL reset_cnt: got %h/%h want 0/0", stall_cnt, flush_cnt); end
        n_checks++; if (proto_err !== 1'b0) begin n_errors++; $display("FAIL reset_proto: got %b want 0", proto_err); end
        rst = 1'b1;
    endtask

    task automatic test_straight_line();
        logic [15:0] fetched;
        set_ctrl(1'b0, 1'b1, 1'b1, 1'b0);
        for (int i = 1; i <= 4; i++) begin
            randomize_id();
            fetched = imem_instr;
            step();
            n_checks++; if (pc !== 16'(i)) begin n_errors++; $display("FAIL straight_pc[%0d]: got %h want %h", i, pc, 16'(i)); end
            n_checks++; if (IFID_pc !== 16'(i - 1)) begin n_errors++; $display("FAIL straight_ifid_pc[%0d]: got %h want %h", i, IFID_pc, 16'(i - 1)); end
            n_checks++; if ({IFID_valid, IFID_instr} !== {1'b1, fetched}) begin
                n_errors++; $display("FAIL straight_ifid[%0d]: got %b/%h want 1/%h", i, IFID_valid, IFID_instr, fetched); end
        end
    endtask

    task automatic test_load_use();
        logic [15:0] held_instr;
        set_ctrl(1'b0, 1'b1, 1'b1, 1'b0);
        randomize_id();
        id_MemRead = 1'b1; id_op1 = 4'h5;
        step();
        n_checks++; if ({IDEX_MemRead, IDEX_op1, IDEX_pc} !== {1'b1, 4'h5, 16'h0003}) begin
            n_errors++; $display("FAIL lw_in_ex: got %b/%h/%h want 1/5/0003", IDEX_MemRead, IDEX_op1, IDEX_pc); end
        held_instr = m_if_instr;
        set_ctrl(1'b1, 1'b0, 1'b0, 1'b0);
        randomize_id();
        step();
        n_checks++; if ({pc, IFID_pc} !== {16'h0005, 16'h0004}) begin
            n_errors++; $display("FAIL stall_hold: got pc=%h ifid_pc=%h want 0005/0004", pc, IFID_pc); end
        n_checks++; if (IFID_instr !== held_instr) begin n_errors++; $display("FAIL stall_hold_instr: got %h want %h", IFID_instr, held_instr); end
        n_checks++; if ({IDEX_MemRead, IDEX_RegWrite, IDEX_op1} !== 6'h0) begin
            n_errors++; $display("FAIL stall_bubble: got %b/%b/%h want 0/0/0", IDEX_MemRead, IDEX_RegWrite, IDEX_op1); end
        n_checks++; if (stall_cnt !== 2'd1) begin n_errors++; $display("FAIL stall_cnt: got %0d want 1", stall_cnt); end
        set_ctrl(1'b0, 1'b1, 1'b1, 1'b0);
        randomize_id();
        id_RegWrite = 1'b1;
        step();
        n_checks++; if ({IDEX_pc, IDEX_RegWrite, pc} !== {16'h0004, 1'b1, 16'h0006}) begin
            n_errors++; $display("FAIL stall_reenter: got idex_pc=%h rw=%b pc=%h want 0004/1/0006", IDEX_pc, IDEX_RegWrite, pc); end
    endtask

    task automatic test_flush();
        set_ctrl(1'b0, 1'b1, 1'b1, 1'b1);
        randomize_id();
        id_RegWrite = 1'b1; br_target = 16'h0040;
        step();
        n_checks++; if (pc !== 16'h0040) begin n_errors++; $display("FAIL flush_pc: got %h want 0040", pc); end
        n_checks++; if ({IFID_instr, IFID_valid} !== 17'h0) begin n_errors++; $display("FAIL flush_ifid: got %h/%b want 0000/0", IFID_instr, IFID_valid); end
        n_checks++; if (IDEX_RegWrite !== 1'b0) begin n_errors++; $display("FAIL flush_idex_rw: got %b want 0", IDEX_RegWrite); end
        n_checks++; if ({flush_cnt, stall_cnt} !== {2'd1, 2'd1}) begin n_errors++; $display("FAIL flush_cnt: got %0d/%0d want 1/1", flush_cnt, stall_cnt); end
    endtask

    task automatic test_flush_stall();
        set_ctrl(1'b1, 1'b0, 1'b0, 1'b1);
        randomize_id();
        id_RegWrite = 1'b1; br_target = 16'h0080;
        step();
        n_checks++; if ({pc, IFID_valid, IDEX_RegWrite} !== {16'h0080, 1'b0, 1'b0}) begin
            n_errors++; $display("FAIL flush_stall_path: got %h/%b/%b want 0080/0/0", pc, IFID_valid, IDEX_RegWrite); end
        n_checks++; if ({stall_cnt, flush_cnt} !== {2'd1, 2'd2}) begin
            n_errors++; $display("FAIL flush_stall_cnt: got stall=%0d flush=%0d want 1/2", stall_cnt, flush_cnt); end
        n_checks++; if (proto_err !== 1'b0) begin n_errors++; $display("FAIL flush_stall_proto: got %b want 0", proto_err); end
    endtask

    task automatic test_proto_err();
        set_ctrl(1'b1, 1'b1, 1'b1, 1'b0);
        randomize_id();
        step();
        n_checks++; if ({proto_err, stall_cnt} !== {1'b1, 2'd2}) begin
            n_errors++; $display("FAIL proto_set: got err=%b stall=%0d want 1/2", proto_err, stall_cnt); end
        n_checks++; if ({pc, IFID_pc, IFID_valid, IDEX_MemRead} !== {16'h0081, 16'h0080, 1'b1, 1'b0}) begin
            n_errors++; $display("FAIL proto_datapath: got %h/%h/%b/%b want 0081/0080/1/0", pc, IFID_pc, IFID_valid, IDEX_MemRead); end
        set_ctrl(1'b0, 1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) begin randomize_id(); step(); end
        n_checks++; if (proto_err !== 1'b1) begin n_errors++; $display("FAIL proto_sticky: got %b want 1", proto_err); end
        set_ctrl(1'b1, 1'b0, 1'b0, 1'b0);
        step();
        n_checks++; if (stall_cnt !== 2'd3) begin n_errors++; $display("FAIL stall_cnt_max: got %0d want 3", stall_cnt); end
        step();
        n_checks++; if (stall_cnt !== 2'd3) begin n_errors++; $display("FAIL stall_cnt_sat: got %0d want 3", stall_cnt); end
        rst = 1'b0;
        step();
        n_checks++; if ({proto_err, stall_cnt, pc} !== {1'b0, 2'd0, 16'h0000}) begin
            n_errors++; $display("FAIL proto_clear: got err=%b stall=%0d pc=%h want 0/0/0000", proto_err, stall_cnt, pc); end
        rst = 1'b1;
    endtask

    task automatic test_random();
        for (int i = 0; i < 600; i++) begin
            rst = ($urandom_range(0, 59) != 0);
            STALL = ($urandom_range(0, 4) == 0);
            br_taken = ($urandom_range(0, 7) == 0);
            if ($urandom_range(0, 19) == 0) begin
                PCWrite = 1'($urandom); IFID_Write = 1'($urandom);
            end else begin
                PCWrite = !STALL; IFID_Write = !STALL;
            end
            br_target = ($urandom_range(0, 3) == 0) ? 16'hFFFE : 16'($urandom);
            randomize_id();
            step();
            n_checks++; if (pc !== m_pc) begin n_errors++; $display("FAIL rand_pc[%0d]: got %h want %h", i, pc, m_pc); end
            n_checks++; if ({IFID_instr, IFID_pc, IFID_valid} !== {m_if_instr, m_if_pc, m_if_vld}) begin
                n_errors++; $display("FAIL rand_ifid[%0d]: got %h/%h/%b want %h/%h/%b", i, IFID_instr, IFID_pc, IFID_valid, m_if_instr, m_if_pc, m_if_vld); end
            n_checks++; if ({IDEX_op1, IDEX_op2, IDEX_rd, IDEX_ctrl, IDEX_MemRead, IDEX_MemWrite, IDEX_RegWrite, IDEX_pc} !==
                            {m_ex_op1, m_ex_op2, m_ex_rd, m_ex_ctrl, m_ex_mr, m_ex_mw, m_ex_rw, m_ex_pc}) begin
                n_errors++; $display("FAIL rand_idex[%0d]: got %h want %h", i,
                    {IDEX_op1, IDEX_op2, IDEX_rd, IDEX_ctrl, IDEX_MemRead, IDEX_MemWrite, IDEX_RegWrite, IDEX_pc},
                    {m_ex_op1, m_ex_op2, m_ex_rd, m_ex_ctrl, m_ex_mr, m_ex_mw, m_ex_rw, m_ex_pc}); end
            n_checks++; if ({stall_cnt, flush_cnt, proto_err} !== {CNT_W'(m_stall), CNT_W'(m_flush), m_err}) begin
                n_errors++; $display("FAIL rand_dbg[%0d]: got %0d/%0d/%b want %0d/%0d/%b", i, stall_cnt, flush_cnt, proto_err, m_stall, m_flush, m_err); end
        end
    endtask

    initial begin
        rst = 1'b0;
        set_ctrl(1'b0, 1'b0, 1'b0, 1'b0);
        br_target = 16'h0000;
        randomize_id();
        test_reset();
        test_straight_line();
        test_load_use();
        test_flush();
        test_flush_stall();
        test_proto_err();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
